// File: rtl/btn_evt_pkg.sv
// Shared types and limits for the button event arbiter.
package btn_evt_pkg;

  localparam int BTN_MAX  = 16;
  localparam int REP_W    = 24;
  localparam int ID_MAX_W = $clog2(BTN_MAX);

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic                is_repeat;
  } btn_evt_t;

endpackage

// File: rtl/button_event_arbiter_rr.sv
// Combinational round-robin picker: first set request after last_grant, wrapping to 0.
module rr_arbiter #(
  parameter  int NUM_BTN = 8,
  localparam int IDW     = $clog2(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic               any,
  output logic [IDW-1:0]     grant
);

  int             idx;
  logic [IDW-1:0] idx_w;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    idx_w = '0;
    // Scan starts one past the previous winner so the last winner has lowest priority.
    for (int k = 1; k <= NUM_BTN; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_BTN) idx = idx - NUM_BTN;
      idx_w = IDW'(idx);
      if (!any && req[idx_w]) begin
        any   = 1'b1;
        grant = idx_w;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into a stream of press / auto-repeat events,
// one pending slot per button, delivered round-robin over valid/ready.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter  int               NUM_BTN       = 8,
  parameter  logic [REP_W-1:0] REPEAT_CYCLES = 24'd12_500_000,
  localparam int               IDW           = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDW-1:0]     evt_id,
  output logic               evt_repeat,
  output logic               overrun
);

  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] pend, pend_rep;
  logic [NUM_BTN-1:0] pend_nxt, pend_rep_nxt;
  logic [NUM_BTN-1:0] press_vec, tick_vec, grant_oh, drop;
  logic [IDW-1:0]     last_grant, arb_grant;
  logic               arb_any;
  btn_evt_t           evt_q;
  logic               evt_valid_q, overrun_q;

  logic [IDW-1:0]     rep_btn;
  logic [REP_W-1:0]   rep_cnt;
  logic               rep_armed;
  logic               rep_hold, rep_tick;
  logic               load, grant_fire, fresh_grant;

  rr_arbiter #(.NUM_BTN(NUM_BTN)) u_rr (
    .req        (pend),
    .last_grant (last_grant),
    .any        (arb_any),
    .grant      (arb_grant)
  );

  assign load        = !evt_valid_q || evt_ready;
  assign grant_fire  = load && arb_any;
  assign fresh_grant = grant_fire && !pend_rep[arb_grant];

  assign rep_hold = enable && btn_in[rep_btn];
  assign rep_tick = (REPEAT_CYCLES != '0) && rep_hold && rep_armed &&
                    (rep_cnt == REPEAT_CYCLES - REP_W'(1));

  assign press_vec = enable ? (btn_in & ~btn_q) : '0;
  assign tick_vec  = rep_tick ? (NUM_BTN'(1) << rep_btn) : '0;
  assign grant_oh  = grant_fire ? (NUM_BTN'(1) << arb_grant) : '0;

  // A free or just-granted slot takes the new event; an occupied slot drops a
  // press (reported) or a repeat tick (silently). A press cannot coincide with
  // a tick on the same button, since a tick needs the level held a cycle earlier.
  always_comb begin
    pend_nxt     = pend;
    pend_rep_nxt = pend_rep;
    drop         = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (grant_oh[i] || !pend[i]) begin
        pend_nxt[i] = press_vec[i] || tick_vec[i];
        if (press_vec[i])
          pend_rep_nxt[i] = 1'b0;
        else if (tick_vec[i])
          pend_rep_nxt[i] = 1'b1;
      end else if (press_vec[i]) begin
        drop[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q       <= '0;
      pend        <= '0;
      pend_rep    <= '0;
      overrun_q   <= 1'b0;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      last_grant  <= IDW'(NUM_BTN - 1);
    end else begin
      btn_q     <= btn_in;
      pend      <= pend_nxt;
      pend_rep  <= pend_rep_nxt;
      overrun_q <= |drop;
      if (load) begin
        if (arb_any) begin
          evt_q.id        <= ID_MAX_W'(arb_grant);
          evt_q.is_repeat <= pend_rep[arb_grant];
          evt_valid_q     <= 1'b1;
          last_grant      <= arb_grant;
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
    end
  end

  // Repeat timer follows the button of the most recent fresh press only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_btn   <= '0;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (fresh_grant) begin
      rep_btn   <= arb_grant;
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else if (!rep_hold) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_armed && (REPEAT_CYCLES != '0)) begin
      if (rep_tick)
        rep_cnt <= '0;
      else
        rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_id     = IDW'(evt_q.id);
  assign evt_repeat = evt_q.is_repeat;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: vector table plus repeat and reset sequences.
module tb_button_event_arbiter;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [2:0]    evt_id;
  logic          evt_repeat;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  button_event_arbiter #(.NUM_BTN(NB), .REPEAT_CYCLES(24'd10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .btn_in     (btn_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_repeat (evt_repeat),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NB-1:0] btn;
    logic          rdy;
    logic          en;
    logic          v;
    logic [2:0]    id;
    logic          rep;
    logic          ov;
  } vec_t;

  vec_t vecs[$];

  int exp_k[4]   = '{1, 12, 22, 32};
  int exp_rep[4] = '{0, 1, 1, 1};
  int got_k[8];
  int got_id[8];
  int got_rep[8];
  int n_ev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [NB-1:0] b, input logic r,
                              input logic e, input logic v, input logic [2:0] id,
                              input logic rep, input logic ov);
    vecs.push_back('{rst, b, r, e, v, id, rep, ov});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    btn_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // single press on button 3, two-cycle latency
    add(1, 8'h08, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 1, 3, 0, 0);
    add(0, 8'h00, 1, 1, 0, 3, 0, 0);
    add(0, 8'h00, 1, 1, 0, 3, 0, 0);
    // button 0 first after reset
    add(1, 8'h81, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 1, 7, 0, 0);
    add(0, 8'h00, 1, 1, 0, 7, 0, 0);
    // burst 1,4,6 twice
    add(1, 8'h52, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 1, 1, 0, 0);
    add(0, 8'h00, 1, 1, 1, 4, 0, 0);
    add(0, 8'h00, 1, 1, 1, 6, 0, 0);
    add(0, 8'h00, 1, 1, 0, 6, 0, 0);
    add(0, 8'h52, 1, 1, 0, 6, 0, 0);
    add(0, 8'h00, 1, 1, 1, 1, 0, 0);
    add(0, 8'h00, 1, 1, 1, 4, 0, 0);
    add(0, 8'h00, 1, 1, 1, 6, 0, 0);
    add(0, 8'h00, 1, 1, 0, 6, 0, 0);
    // enable low: pending 7 drains, press on 0 ignored
    add(0, 8'h04, 0, 1, 0, 6, 0, 0);
    add(0, 8'h00, 0, 1, 1, 2, 0, 0);
    add(0, 8'h80, 0, 1, 1, 2, 0, 0);
    add(0, 8'h01, 0, 0, 1, 2, 0, 0);
    add(0, 8'h00, 1, 0, 1, 7, 0, 0);
    add(0, 8'h00, 1, 0, 0, 7, 0, 0);
    add(0, 8'h00, 1, 1, 0, 7, 0, 0);
    // overrun on button 2 while output stalled on button 1
    add(0, 8'h02, 0, 1, 0, 7, 0, 0);
    add(0, 8'h00, 0, 1, 1, 1, 0, 0);
    add(0, 8'h04, 0, 1, 1, 1, 0, 0);
    add(0, 8'h00, 0, 1, 1, 1, 0, 0);
    add(0, 8'h04, 0, 1, 1, 1, 0, 1);
    add(0, 8'h00, 0, 1, 1, 1, 0, 0);
    add(0, 8'h00, 1, 1, 1, 2, 0, 0);
    add(0, 8'h00, 1, 1, 0, 2, 0, 0);
    add(0, 8'h00, 1, 1, 0, 2, 0, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset valid", evt_valid, 0);
    chk("reset id", evt_id, 0);
    chk("reset repeat", evt_repeat, 0);
    chk("reset overrun", overrun, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      btn_in    = vecs[i].btn;
      evt_ready = vecs[i].rdy;
      enable    = vecs[i].en;
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), evt_valid, vecs[i].v);
      chk($sformatf("vec%0d id", i), evt_id, vecs[i].id);
      chk($sformatf("vec%0d repeat", i), evt_repeat, vecs[i].rep);
      chk($sformatf("vec%0d overrun", i), overrun, vecs[i].ov);
    end

    // auto-repeat: hold button 5 for 35 cycles after its grant
    evt_ready = 1'b1;
    enable    = 1'b1;
    n_ev      = 0;
    btn_in    = 8'h20;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (evt_valid) begin
        if (n_ev < 8) begin
          got_k[n_ev]   = k;
          got_id[n_ev]  = int'(evt_id);
          got_rep[n_ev] = int'(evt_repeat);
        end
        n_ev++;
      end
      if (k == 35) btn_in = '0;
    end
    chk("repeat event count", n_ev, 4);
    for (int j = 0; j < 4 && j < n_ev; j++) begin
      chk($sformatf("repeat ev%0d cycle", j), got_k[j], exp_k[j]);
      chk($sformatf("repeat ev%0d id", j), got_id[j], 5);
      chk($sformatf("repeat ev%0d flag", j), got_rep[j], exp_rep[j]);
    end

    // reset while an event is presented and more are pending
    evt_ready = 1'b0;
    btn_in    = 8'h0E;
    @(negedge clk);
    btn_in = '0;
    @(negedge clk);
    chk("pre-reset valid", evt_valid, 1);
    chk("pre-reset id", evt_id, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", evt_valid, 0);
    chk("async reset id", evt_id, 0);
    chk("async reset repeat", evt_repeat, 0);
    chk("async reset overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    n_ev      = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (evt_valid) n_ev++;
    end
    chk("post-reset events", n_ev, 0);

    // button already high at reset release gives one press
    rst_n  = 1'b0;
    btn_in = 8'h08;
    @(negedge clk);
    rst_n = 1'b1;
    n_ev  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (evt_valid) begin
        if (n_ev < 8) begin
          got_id[n_ev]  = int'(evt_id);
          got_rep[n_ev] = int'(evt_repeat);
        end
        n_ev++;
      end
      if (k == 2) btn_in = '0;
    end
    chk("held-at-reset count", n_ev, 1);
    if (n_ev > 0) begin
      chk("held-at-reset id", got_id[0], 3);
      chk("held-at-reset flag", got_rep[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
